// File: rtl/vram_line_fetcher_pkg.sv
// Shared types and helpers for the VRAM line fetcher: bus widths, fetch FSM
// states and the nibble ordering used to unpack 4bpp bitmap words.
package vram_line_fetcher_pkg;

  localparam int VRAM_ADDR_W = 13;
  localparam int VRAM_DATA_W = 16;
  localparam int PIX_W       = 4;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LAST
  } fetch_state_e;

  // Pixels are packed low byte first, high nibble first within each byte.
  function automatic logic [PIX_W-1:0] nibble_sel(input logic [VRAM_DATA_W-1:0] data_word,
                                                  input logic [1:0]             sel);
    logic [PIX_W-1:0] nib;
    unique case (sel)
      2'd0:    nib = data_word[7:4];
      2'd1:    nib = data_word[3:0];
      2'd2:    nib = data_word[15:12];
      default: nib = data_word[11:8];
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/vram_line_fetcher_line_buffer.sv
// Ping-pong scanline store: two banks of WORDS_PER_LINE words, one write port
// and one registered read port, addressed by {bank, index}.
module line_buffer
  import vram_line_fetcher_pkg::*;
#(
  parameter int WORDS_PER_LINE = 80,
  parameter int IDX_W          = 7
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic                   wr_bank,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [VRAM_DATA_W-1:0] wr_data,
  input  logic                   rd_bank,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [VRAM_DATA_W-1:0] rd_data
);

  localparam int ADDR_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(WORDS_PER_LINE);

  logic [VRAM_DATA_W-1:0] mem [2*WORDS_PER_LINE];
  logic [ADDR_W-1:0]      wr_addr;
  logic [ADDR_W-1:0]      rd_addr;
  logic [VRAM_DATA_W-1:0] rd_data_q;

  // Banks are packed back to back so the storage is exactly two lines deep.
  always_comb begin
    wr_addr = {1'b0, wr_idx};
    rd_addr = {1'b0, rd_idx};
    if (wr_bank) wr_addr = {1'b0, wr_idx} + BANK_OFFSET;
    if (rd_bank) rd_addr = {1'b0, rd_idx} + BANK_OFFSET;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/vram_line_fetcher.sv
// Burst-reads one 4bpp scanline from VRAM port 2 into a ping-pong buffer and
// streams it out as 4-bit pixels while the next line is being fetched.
module vram_line_fetcher
  import vram_line_fetcher_pkg::*;
#(
  parameter int WORDS_PER_LINE = 80,
  parameter int IDX_W          = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   line_start,
  input  logic [VRAM_ADDR_W-1:0] line_base,
  output logic [VRAM_ADDR_W-1:0] vram_addr,
  input  logic [VRAM_DATA_W-1:0] vram_rddata,
  output logic                   fetch_busy,
  output logic                   overrun,
  input  logic                   pix_start,
  input  logic                   pix_next,
  output logic [PIX_W-1:0]       pix_data,
  output logic                   pix_valid
);

  localparam int PIX_IDX_W = IDX_W + 2;
  localparam logic [IDX_W-1:0]     LAST_WIDX = IDX_W'(WORDS_PER_LINE - 1);
  localparam logic [PIX_IDX_W-1:0] LAST_PIX  = PIX_IDX_W'(WORDS_PER_LINE * 4 - 1);

  fetch_state_e           state_q, state_d;
  logic [IDX_W-1:0]       widx_q, widx_d;
  logic [VRAM_ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic                   fetch_busy_q, fetch_busy_d;
  logic                   overrun_q, overrun_d;
  logic                   fill_bank_q, fill_bank_d;
  logic                   ready_bank_q, ready_bank_d;
  logic                   have_line_q, have_line_d;
  logic                   buf_wr_en;
  logic [IDX_W-1:0]       buf_wr_idx;

  logic                   pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]       pix_data_q, pix_data_d;
  logic [PIX_IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [VRAM_DATA_W-1:0] word_q, word_d;
  logic                   disp_bank_q, disp_bank_d;
  logic                   load_q, load_d;
  logic                   start_ok;
  logic [IDX_W-1:0]       cur_word_idx;
  logic                   rd_bank;
  logic [IDX_W-1:0]       rd_idx;
  logic [VRAM_DATA_W-1:0] buf_rd_data;

  // Fetch FSM state register, together with the registers it owns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      widx_q       <= '0;
      vram_addr_q  <= '0;
      fetch_busy_q <= 1'b0;
      overrun_q    <= 1'b0;
      fill_bank_q  <= 1'b0;
      ready_bank_q <= 1'b0;
      have_line_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      widx_q       <= widx_d;
      vram_addr_q  <= vram_addr_d;
      fetch_busy_q <= fetch_busy_d;
      overrun_q    <= overrun_d;
      fill_bank_q  <= fill_bank_d;
      ready_bank_q <= ready_bank_d;
      have_line_q  <= have_line_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (line_start) state_d = FETCH;
      FETCH:   if (widx_q == LAST_WIDX) state_d = LAST;
      LAST:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // widx tracks the word whose address is on the bus; read data lags by one,
  // so writes land at widx-1 and LAST picks up the final word.
  always_comb begin
    widx_d       = widx_q;
    vram_addr_d  = vram_addr_q;
    fetch_busy_d = fetch_busy_q;
    fill_bank_d  = fill_bank_q;
    ready_bank_d = ready_bank_q;
    have_line_d  = have_line_q;
    overrun_d    = line_start & fetch_busy_q;
    buf_wr_en    = 1'b0;
    buf_wr_idx   = widx_q - IDX_W'(1);
    unique case (state_q)
      IDLE: begin
        if (line_start) begin
          vram_addr_d  = line_base;
          widx_d       = '0;
          fetch_busy_d = 1'b1;
        end
      end
      FETCH: begin
        vram_addr_d = vram_addr_q + VRAM_ADDR_W'(1);
        widx_d      = widx_q + IDX_W'(1);
        buf_wr_en   = (widx_q != '0);
      end
      LAST: begin
        buf_wr_en    = 1'b1;
        ready_bank_d = fill_bank_q;
        fill_bank_d  = ~fill_bank_q;
        have_line_d  = 1'b1;
        fetch_busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_idx_q   <= '0;
      word_q      <= '0;
      disp_bank_q <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      pix_idx_q   <= pix_idx_d;
      word_q      <= word_d;
      disp_bank_q <= disp_bank_d;
      load_q      <= load_d;
    end
  end

  // The read port always points one word ahead of the one on display, so the
  // next word is already waiting when the fourth pixel is consumed.
  always_comb begin
    start_ok     = pix_start & have_line_q;
    cur_word_idx = pix_idx_q[PIX_IDX_W-1:2];
    rd_bank      = disp_bank_q;
    rd_idx       = (cur_word_idx == LAST_WIDX) ? cur_word_idx : cur_word_idx + IDX_W'(1);
    if (start_ok) begin
      rd_bank = ready_bank_q;
      rd_idx  = '0;
    end
  end

  always_comb begin
    pix_valid_d = pix_valid_q;
    pix_data_d  = pix_data_q;
    pix_idx_d   = pix_idx_q;
    word_d      = word_q;
    disp_bank_d = disp_bank_q;
    load_d      = 1'b0;
    if (start_ok) begin
      disp_bank_d = ready_bank_q;
      pix_idx_d   = '0;
      load_d      = 1'b1;
      pix_valid_d = 1'b0;
      pix_data_d  = '0;
    end else if (load_q) begin
      word_d      = buf_rd_data;
      pix_data_d  = nibble_sel(buf_rd_data, 2'd0);
      pix_valid_d = 1'b1;
    end else if (pix_valid_q && pix_next) begin
      if (pix_idx_q == LAST_PIX) begin
        pix_valid_d = 1'b0;
        pix_data_d  = '0;
      end else begin
        pix_idx_d = pix_idx_q + PIX_IDX_W'(1);
        if (pix_idx_q[1:0] == 2'd3) begin
          word_d     = buf_rd_data;
          pix_data_d = nibble_sel(buf_rd_data, 2'd0);
        end else begin
          pix_data_d = nibble_sel(word_q, pix_idx_q[1:0] + 2'd1);
        end
      end
    end
  end

  line_buffer #(
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .IDX_W         (IDX_W)
  ) u_line_buffer (
    .clk    (clk),
    .wr_en  (buf_wr_en),
    .wr_bank(fill_bank_q),
    .wr_idx (buf_wr_idx),
    .wr_data(vram_rddata),
    .rd_bank(rd_bank),
    .rd_idx (rd_idx),
    .rd_data(buf_rd_data)
  );

  assign vram_addr  = vram_addr_q;
  assign fetch_busy = fetch_busy_q;
  assign overrun    = overrun_q;
  assign pix_data   = pix_data_q;
  assign pix_valid  = pix_valid_q;

endmodule

// File: tb/tb_vram_line_fetcher.sv
// Scoreboard bench for vram_line_fetcher: a behavioural VRAM plus a line-level
// reference model queue expected pixels that an independent monitor checks.
module tb_vram_line_fetcher;

  localparam int WPL = 80;

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic [12:0] line_base;
  logic [12:0] vram_addr;
  logic [15:0] vram_rddata;
  logic        fetch_busy;
  logic        overrun;
  logic        pix_start;
  logic        pix_next;
  logic [3:0]  pix_data;
  logic        pix_valid;

  int tests_run    = 0;
  int tests_failed = 0;
  int cycle_cnt    = 0;

  logic [15:0] vmem [8192];
  logic [15:0] ready_line [WPL];
  bit          model_have_line = 1'b0;
  logic [3:0]  exp_q [$];
  bit          random_next = 1'b0;

  always #5 clk = ~clk;

  vram_line_fetcher #(.WORDS_PER_LINE(WPL), .IDX_W(7)) dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_base  (line_base),
    .vram_addr  (vram_addr),
    .vram_rddata(vram_rddata),
    .fetch_busy (fetch_busy),
    .overrun    (overrun),
    .pix_start  (pix_start),
    .pix_next   (pix_next),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid)
  );

  // Synchronous-read VRAM port with one cycle of latency.
  always @(posedge clk) vram_rddata <= vmem[vram_addr];

  always @(posedge clk) cycle_cnt++;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pixel order is low byte before high byte, high nibble first.
  task automatic push_line();
    int shifts [4] = '{4, 0, 12, 8};
    for (int w = 0; w < WPL; w++)
      for (int p = 0; p < 4; p++)
        exp_q.push_back(4'((ready_line[w] >> shifts[p]) & 16'h000F));
  endtask

  task automatic applyStimulus(input bit ls, input logic [12:0] base, input bit ps);
    line_start = ls;
    line_base  = base;
    pix_start  = ps;
    if (ps && model_have_line) push_line();
    tick();
    line_start = 1'b0;
    pix_start  = 1'b0;
  endtask

  task automatic run_fetch(input logic [12:0] base, input int inject_at, input logic [12:0] inject_base);
    int cycles;
    int addr_errs;
    int ovr;
    applyStimulus(1'b1, base, 1'b0);
    cycles    = 1;
    addr_errs = 0;
    ovr       = 0;
    while (fetch_busy && cycles < 200) begin
      if (overrun) ovr++;
      if (cycles - 1 < WPL && vram_addr != 13'(int'(base) + cycles - 1)) addr_errs++;
      if (cycles == inject_at) applyStimulus(1'b1, inject_base, 1'b0);
      else tick();
      cycles++;
    end
    checkOutput("vram_addr sequence errors", addr_errs, 0);
    checkOutput("fetch_busy cycles", cycles, WPL + 2);
    checkOutput("overrun pulses", ovr, (inject_at > 0) ? 1 : 0);
    for (int i = 0; i < WPL; i++) ready_line[i] = vmem[13'(int'(base) + i)];
    model_have_line = 1'b1;
  endtask

  task automatic start_stream(output int start_cycle);
    start_cycle = cycle_cnt;
    applyStimulus(1'b0, 13'h0, 1'b1);
  endtask

  task automatic wait_stream(input int start_cycle, input bit check_time);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 5000) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("stream timeout, pixels left", exp_q.size(), 0);
      exp_q.delete();
    end else begin
      if (check_time) checkOutput("stream length in cycles", cycle_cnt - start_cycle, WPL * 4 + 2);
      checkOutput("pix_valid after last pixel", int'(pix_valid), 0);
      checkOutput("pix_data after last pixel", int'(pix_data), 0);
    end
  endtask

  // Monitor: every valid cycle must show the head of the queue; pix_next consumes it.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && pix_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("pix_valid with no pixel expected", int'(pix_valid), 0);
        end else begin
          checkOutput("pix_data", int'(pix_data), int'(exp_q[0]));
          if (pix_next) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    pix_next = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_next = random_next ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int seen;
    reset      = 1'b1;
    line_start = 1'b0;
    line_base  = '0;
    pix_start  = 1'b0;
    for (int i = 0; i < 8192; i++) vmem[i] = 16'($urandom);
    for (int i = 16'h0100; i < 16'h0150; i++) vmem[i] = 16'(i);
    for (int i = 16'h0400; i < 16'h0450; i++) vmem[i] = 16'hA5A5;

    repeat (3) tick();
    checkOutput("reset vram_addr", int'(vram_addr), 0);
    checkOutput("reset fetch_busy", int'(fetch_busy), 0);
    checkOutput("reset overrun", int'(overrun), 0);
    checkOutput("reset pix_valid", int'(pix_valid), 0);
    checkOutput("reset pix_data", int'(pix_data), 0);
    reset = 1'b0;
    repeat (2) tick();

    $display("[TB] line 0x0100 fetch and held-next stream");
    run_fetch(13'h0100, -1, 13'h0);
    start_stream(t0);
    wait_stream(t0, 1'b1);

    $display("[TB] wrapping fetch at 0x1FF0, random pix_next");
    random_next = 1'b1;
    run_fetch(13'h1FF0, -1, 13'h0);
    checkOutput("wrapped word index 16", int'(ready_line[16]), int'(vmem[0]));
    start_stream(t0);
    wait_stream(t0, 1'b0);

    $display("[TB] overrun during fetch of 0x0200");
    run_fetch(13'h0200, 10, 13'h0300);
    repeat (3) tick();
    checkOutput("fetch_busy idle after overrun", int'(fetch_busy), 0);

    $display("[TB] stream 0x0200 while fetching 0x0400");
    start_stream(t0);
    repeat (5) tick();
    run_fetch(13'h0400, -1, 13'h0);
    wait_stream(t0, 1'b0);
    random_next = 1'b0;
    start_stream(t0);
    wait_stream(t0, 1'b1);

    $display("[TB] reset in the middle of a fetch");
    applyStimulus(1'b1, 13'h0500, 1'b0);
    repeat (40) tick();
    reset = 1'b1;
    #1;
    checkOutput("mid-fetch reset fetch_busy", int'(fetch_busy), 0);
    checkOutput("mid-fetch reset vram_addr", int'(vram_addr), 0);
    model_have_line = 1'b0;
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    applyStimulus(1'b0, 13'h0, 1'b1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (pix_valid) seen++;
      tick();
    end
    checkOutput("pix_valid after start without line", seen, 0);
    random_next = 1'b1;
    run_fetch(13'h0500, -1, 13'h0);
    start_stream(t0);
    wait_stream(t0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
